// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the ALU request scheduler.
//  state_t      : scheduler FSM states
//  alu_flags_t  : ALU flag bundle {err,oflow,cout,g,l,e}
//  op_latency() : ALU latency for a given mode/cmd
package alu_sched_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] CMD_MUL_INC = 4'd9;
   localparam logic [3:0] CMD_MUL_SHL = 4'd10;

   typedef struct packed {
      logic err;
      logic oflow;
      logic cout;
      logic g;
      logic l;
      logic e;
   } alu_flags_t;

   // Multiply commands only exist in arithmetic mode and take the longer latency
   function automatic int unsigned op_latency(input logic        mode,
                                              input logic [3:0]  cmd,
                                              input int unsigned lat,
                                              input int unsigned lat_mul);
      return (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL)) ? lat_mul : lat;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//  req     : request vector
//  ptr     : highest-priority index this cycle
//  gnt     : one-hot grant (first set req at or after ptr, wrapping)
//  gnt_idx : binary index of the grant (0 when nothing is requested)
module rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic             found;
   logic [IDX_W-1:0] idx;

   // Scan N positions starting at ptr; the first hit wins
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = IDX_W'((32'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_idx    = idx;
         end
      end
   end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU among N requesters, one operation in flight.
//  req_*   : per-requester valid/payload, req_ready is a one-hot accept in IDLE
//  rsp_*   : captured result/flags and requester id, valid/ready handshake
//  alu_*   : latched operands/command toward the ALU, result/flags back
//  busy    : scheduler is not idle
`ifndef WIDTH
`define WIDTH 8
`endif
module alu_req_scheduler
   import alu_sched_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned W       = `WIDTH,
   parameter int unsigned LAT     = 1,
   parameter int unsigned LAT_MUL = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req_valid,
   output logic [N-1:0]           req_ready,
   input  logic [N-1:0]           req_mode,
   input  logic [4*N-1:0]         req_cmd,
   input  logic [N-1:0]           req_cin,
   input  logic [W*N-1:0]         req_opa,
   input  logic [W*N-1:0]         req_opb,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [$clog2(N)-1:0]   rsp_id,
   output logic [W:0]             rsp_res,
   output logic [5:0]             rsp_flags,
   output logic                   alu_ce,
   output logic [1:0]             alu_inp_valid,
   output logic                   alu_mode,
   output logic [3:0]             alu_cmd,
   output logic                   alu_cin,
   output logic [W-1:0]           alu_opa,
   output logic [W-1:0]           alu_opb,
   input  logic [W:0]             alu_res,
   input  logic                   alu_err,
   input  logic                   alu_oflow,
   input  logic                   alu_cout,
   input  logic                   alu_g,
   input  logic                   alu_l,
   input  logic                   alu_e,
   output logic                   busy
);

   localparam int unsigned IDX_W   = $clog2(N);
   localparam int unsigned LAT_MAX = (LAT > LAT_MUL) ? LAT : LAT_MUL;
   localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] id_q;
   logic [CNT_W-1:0] cnt_q;
   logic [N-1:0]     gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             grant_c;
   logic             sample_c;
   alu_flags_t       flags_c;

   logic             sel_mode;
   logic [3:0]       sel_cmd;
   logic             sel_cin;
   logic [W-1:0]     sel_opa;
   logic [W-1:0]     sel_opb;

   rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign grant_c  = (state_q == IDLE) && (|req_valid);
   assign sample_c = (state_q == WAIT) && (cnt_q == CNT_W'(1));
   assign flags_c  = {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};

   // Accept only in IDLE; also held low while reset is asserted
   assign req_ready = (state_q == IDLE && rst) ? gnt : '0;

   // Payload mux for the granted requester
   always_comb begin
      sel_mode = 1'b0;
      sel_cmd  = '0;
      sel_cin  = 1'b0;
      sel_opa  = '0;
      sel_opb  = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            sel_mode = req_mode[i];
            sel_cmd  = req_cmd[4*i +: 4];
            sel_cin  = req_cin[i];
            sel_opa  = req_opa[W*i +: W];
            sel_opb  = req_opb[W*i +: W];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|req_valid) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pointer, operand latches, latency counter, response capture and
   // registered status outputs (decoded from the next state)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q         <= '0;
         id_q          <= '0;
         cnt_q         <= '0;
         alu_ce        <= 1'b0;
         alu_inp_valid <= 2'b00;
         alu_mode      <= 1'b0;
         alu_cmd       <= '0;
         alu_cin       <= 1'b0;
         alu_opa       <= '0;
         alu_opb       <= '0;
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_res       <= '0;
         rsp_flags     <= '0;
         busy          <= 1'b0;
      end else begin
         alu_ce        <= (state_d == ISSUE) || (state_d == WAIT);
         alu_inp_valid <= (state_d == ISSUE) ? 2'b11 : 2'b00;
         busy          <= (state_d != IDLE);
         rsp_valid     <= (state_d == RESP);

         if (grant_c) begin
            ptr_q    <= IDX_W'((32'(gnt_idx) + 32'd1) % N);
            id_q     <= gnt_idx;
            alu_mode <= sel_mode;
            alu_cmd  <= sel_cmd;
            alu_cin  <= sel_cin;
            alu_opa  <= sel_opa;
            alu_opb  <= sel_opb;
         end

         if (state_q == ISSUE)
            cnt_q <= CNT_W'(op_latency(alu_mode, alu_cmd, LAT, LAT_MUL));
         else if (state_q == WAIT)
            cnt_q <= cnt_q - CNT_W'(1);

         if (sample_c) begin
            rsp_res   <= alu_res;
            rsp_flags <= flags_c;
            rsp_id    <= id_q;
         end
      end
   end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler with a behavioural ALU that only
// presents a valid result exactly at the expected latency after issue.
module tb_alu_req_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   req_mode;
   logic [4*N-1:0] req_cmd;
   logic [N-1:0]   req_cin;
   logic [W*N-1:0] req_opa;
   logic [W*N-1:0] req_opb;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [W:0]     rsp_res;
   logic [5:0]     rsp_flags;
   logic           alu_ce;
   logic [1:0]     alu_inp_valid;
   logic           alu_mode;
   logic [3:0]     alu_cmd;
   logic           alu_cin;
   logic [W-1:0]   alu_opa;
   logic [W-1:0]   alu_opb;
   logic [W:0]     alu_res;
   logic           alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;
   logic           busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_req_scheduler #(.N(N), .W(W), .LAT(1), .LAT_MUL(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_mode      (req_mode),
      .req_cmd       (req_cmd),
      .req_cin       (req_cin),
      .req_opa       (req_opa),
      .req_opb       (req_opb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_res       (rsp_res),
      .rsp_flags     (rsp_flags),
      .alu_ce        (alu_ce),
      .alu_inp_valid (alu_inp_valid),
      .alu_mode      (alu_mode),
      .alu_cmd       (alu_cmd),
      .alu_cin       (alu_cin),
      .alu_opa       (alu_opa),
      .alu_opb       (alu_opb),
      .alu_res       (alu_res),
      .alu_err       (alu_err),
      .alu_oflow     (alu_oflow),
      .alu_cout      (alu_cout),
      .alu_g         (alu_g),
      .alu_l         (alu_l),
      .alu_e         (alu_e),
      .busy          (busy)
   );

   // Behavioural ALU: age counts cycles since the issue cycle; outputs are
   // garbage (res all ones, all flags set) except when age equals the latency.
   logic [3:0] age;
   logic [3:0] lat_exp;
   logic [W:0] true_res;

   always @(posedge clk or negedge rst) begin
      if (!rst)                          age <= 4'd0;
      else if (alu_inp_valid == 2'b11)   age <= 4'd1;
      else if (age != 4'd0 && age < 4'd15) age <= age + 4'd1;
   end

   always_comb begin
      lat_exp = (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? 4'd2 : 4'd1;
      if (alu_mode && alu_cmd == 4'd0)
         true_res = {1'b0, alu_opa} + {1'b0, alu_opb};
      else if (alu_mode && alu_cmd == 4'd9)
         true_res = 9'((32'(alu_opa) + 32'd1) * (32'(alu_opb) + 32'd1));
      else
         true_res = {1'b0, alu_opa ^ alu_opb};
      if (age == lat_exp) begin
         alu_res   = true_res;
         alu_err   = !alu_mode && (alu_cmd >= 4'd14);
         alu_oflow = 1'b0;
         alu_cout  = true_res[W];
         alu_g     = alu_opa > alu_opb;
         alu_l     = alu_opa < alu_opb;
         alu_e     = alu_opa == alu_opb;
      end else begin
         alu_res   = '1;
         alu_err   = 1'b1;
         alu_oflow = 1'b1;
         alu_cout  = 1'b1;
         alu_g     = 1'b1;
         alu_l     = 1'b1;
         alu_e     = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic mode, input logic [3:0] cmd,
                          input logic cin, input logic [W-1:0] opa, input logic [W-1:0] opb);
      req_mode[i]          = mode;
      req_cmd[4*i +: 4]    = cmd;
      req_cin[i]           = cin;
      req_opa[W*i +: W]    = opa;
      req_opb[W*i +: W]    = opb;
   endtask

   task automatic wait_rsp(input string tag);
      int c = 0;
      while (!rsp_valid && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk(tag, 32'(rsp_valid), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_ids [5];
      int gseq    [5];
      int gcyc    [5];
      int ng, nr, cyc;

      exp_ids   = '{0, 1, 2, 3, 0};
      gseq      = '{0, 0, 0, 0, 0};
      gcyc      = '{0, 0, 0, 0, 0};
      req_valid = '0;
      req_mode  = '0;
      req_cmd   = '0;
      req_cin   = '0;
      req_opa   = '0;
      req_opb   = '0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_ce", 32'(alu_ce), 32'd0);
      chk("rst_inp_valid", 32'(alu_inp_valid), 32'd0);
      chk("rst_rsp_res", 32'(rsp_res), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // 1: single requester, add 0x0F + 0x01
      set_req(0, 1'b1, 4'd0, 1'b0, 8'h0F, 8'h01);
      req_valid = 4'b0001;
      #1 chk("t1_req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = '0;
      chk("t1_issue_inp_valid", 32'(alu_inp_valid), 32'h3);
      chk("t1_issue_ce", 32'(alu_ce), 32'd1);
      chk("t1_issue_busy", 32'(busy), 32'd1);
      chk("t1_issue_opa", 32'(alu_opa), 32'h0F);
      chk("t1_issue_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("t1_wait_inp_valid", 32'(alu_inp_valid), 32'h0);
      chk("t1_wait_ce", 32'(alu_ce), 32'd1);
      chk("t1_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1_rsp_res", 32'(rsp_res), 32'h010);
      chk("t1_rsp_id", 32'(rsp_id), 32'd0);
      chk("t1_rsp_flags", 32'(rsp_flags), 32'b000100);
      chk("t1_rsp_ce", 32'(alu_ce), 32'd0);
      @(negedge clk);
      chk("t1_done_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t1_done_busy", 32'(busy), 32'd0);

      // 2: all four held valid after a fresh reset -> 0,1,2,3,0
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'd1, 1'b0, 8'(i), 8'h00);
      req_valid = 4'b1111;
      ng = 0; nr = 0; cyc = 0;
      while (ng < 5 && cyc < 40) begin
         #1;
         if (req_ready != '0) begin
            chk("t2_onehot", 32'($countones(req_ready)), 32'd1);
            for (int i = 0; i < N; i++) if (req_ready[i]) gseq[ng] = i;
            gcyc[ng] = cyc;
            ng++;
         end
         if (rsp_valid && nr < 5) begin
            chk("t2_rsp_id", 32'(rsp_id), 32'(exp_ids[nr]));
            chk("t2_rsp_res", 32'(rsp_res), 32'(exp_ids[nr]));
            nr++;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = '0;
      chk("t2_grant_count", 32'(ng), 32'd5);
      for (int k = 0; k < 5; k++) chk("t2_grant_order", 32'(gseq[k]), 32'(exp_ids[k]));
      chk("t2_throughput", 32'(gcyc[1] - gcyc[0]), 32'd4);
      wait_rsp("t2_last_rsp");
      chk("t2_last_rsp_id", 32'(rsp_id), 32'd0);
      @(negedge clk);

      // 3: multiply takes two WAIT cycles
      set_req(2, 1'b1, 4'd9, 1'b0, 8'h03, 8'h04);
      req_valid = 4'b0100;
      #1 chk("t3_req_ready", 32'(req_ready), 32'h4);
      @(negedge clk);
      req_valid = '0;
      chk("t3_issue", 32'(alu_inp_valid), 32'h3);
      @(negedge clk);
      chk("t3_wait1_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("t3_wait2_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t3_wait2_ce", 32'(alu_ce), 32'd1);
      @(negedge clk);
      chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t3_rsp_res", 32'(rsp_res), 32'h014);
      chk("t3_rsp_id", 32'(rsp_id), 32'd2);
      chk("t3_rsp_flags", 32'(rsp_flags), 32'b000010);
      @(negedge clk);
      chk("t3_idle", 32'(busy), 32'd0);

      // 4: backpressure in RESP for 5 cycles
      rsp_ready = 1'b0;
      set_req(3, 1'b1, 4'd0, 1'b0, 8'hAA, 8'h55);
      req_valid = 4'b1000;
      @(negedge clk);
      req_valid = '0;
      wait_rsp("t4_rsp");
      set_req(0, 1'b0, 4'd0, 1'b0, 8'h01, 8'h01);
      req_valid = 4'b0001;
      chk("t4_rsp_flags", 32'(rsp_flags), 32'b000100);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
         chk("t4_hold_res", 32'(rsp_res), 32'h0FF);
         chk("t4_hold_id", 32'(rsp_id), 32'd3);
         chk("t4_hold_ready", 32'(req_ready), 32'd0);
         chk("t4_hold_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1 chk("t4_regrant", 32'(req_ready), 32'h1);
      chk("t4_rsp_cleared", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      req_valid = '0;
      wait_rsp("t4_rsp2");
      chk("t4_rsp2_id", 32'(rsp_id), 32'd0);
      chk("t4_rsp2_res", 32'(rsp_res), 32'h000);
      @(negedge clk);

      // 5: reset during WAIT abandons the op and clears the pointer
      set_req(1, 1'b1, 4'd9, 1'b0, 8'h02, 8'h02);
      set_req(3, 1'b0, 4'd1, 1'b0, 8'h07, 8'h00);
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      chk("t5_in_wait", 32'(alu_ce), 32'd1);
      req_valid = 4'b1010;
      rst = 1'b0;
      #1;
      chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_ce", 32'(alu_ce), 32'd0);
      chk("t5_rst_inp_valid", 32'(alu_inp_valid), 32'd0);
      chk("t5_rst_opa", 32'(alu_opa), 32'd0);
      chk("t5_rst_cmd", 32'(alu_cmd), 32'd0);
      chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
      chk("t5_lowest_grant", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid = 4'b1000;
      wait_rsp("t5_rsp");
      chk("t5_rsp_id", 32'(rsp_id), 32'd1);
      chk("t5_rsp_res", 32'(rsp_res), 32'h009);
      @(negedge clk);
      #1 chk("t5_next_grant", 32'(req_ready), 32'h8);
      @(negedge clk);
      req_valid = '0;
      wait_rsp("t5_rsp2");
      chk("t5_rsp2_id", 32'(rsp_id), 32'd3);
      @(negedge clk);

      // 6: invalid logic cmd, ALU error passes through
      set_req(0, 1'b0, 4'd14, 1'b0, 8'h01, 8'h02);
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = '0;
      wait_rsp("t6_rsp");
      chk("t6_err_flag", 32'(rsp_flags[5]), 32'd1);
      chk("t6_flags", 32'(rsp_flags), 32'b100010);
      chk("t6_rsp_id", 32'(rsp_id), 32'd0);
      chk("t6_rsp_res", 32'(rsp_res), 32'h003);
      @(negedge clk);
      chk("t6_idle", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
